// File: rtl/cla_adder_pipelined.sv
// -----------------------------------------------------------------------------
// cla_adder_pipelined
//
// Pipelined carry-look-ahead adder/subtractor with valid/ready handshakes.
// Operands are cut into GROUP-bit look-ahead groups. Inside a group every
// carry is a flat sum-of-products of the group generate/propagate terms and
// the group carry-in. Carries ripple from group to group, and PIPE_GROUPS
// groups share one pipeline stage. The design therefore has
// STAGES = WIDTH / (GROUP * PIPE_GROUPS) register stages and accepts one
// operation per clock.
//
// The pipeline is a rigid shift register with a single advance enable. It
// stalls only when the output register holds a result that downstream is not
// taking.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   operand beat valid
//   in_ready   block can accept a beat this cycle (combinational)
//   a, b       operands, WIDTH bits
//   c_in       carry-in for add, borrow-in for subtract
//   sub        0 = a + b + c_in, 1 = a - b - c_in
//   out_valid  result beat valid (registered)
//   out_ready  downstream accepts the result
//   sum        result modulo 2^WIDTH (registered)
//   c_out      raw carry out of bit WIDTH-1; borrow-out is ~c_out (registered)
//   ovf        two's-complement signed overflow (registered)
//
// WIDTH must be a multiple of GROUP * PIPE_GROUPS.
// -----------------------------------------------------------------------------
module cla_adder_pipelined #(
  parameter int WIDTH       = 32,
  parameter int GROUP       = 4,
  parameter int PIPE_GROUPS = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int SLICE  = GROUP * PIPE_GROUPS;
  localparam int STAGES = WIDTH / SLICE;

  // One look-ahead group. The return value is packed as:
  //   {carry out of the group, carry into the group MSB, group sum}
  // Every carry c[i] is expanded into its full product form, so each one
  // depends only on g/p and the group carry-in, and not on c[i-1]:
  //   c[i] = g[i-1] | p[i-1]g[i-2] | ... | p[i-1..0]c0
  function automatic logic [GROUP+1:0] cla_group(
    input logic [GROUP-1:0] ga,
    input logic [GROUP-1:0] gb,
    input logic             gc
  );
    logic [GROUP-1:0] g;
    logic [GROUP-1:0] p;
    logic [GROUP:0]   c;
    logic             term;
    g    = ga & gb;
    p    = ga ^ gb;
    c    = '0;
    c[0] = gc;
    for (int i = 1; i <= GROUP; i++) begin
      term = gc;
      for (int j = 0; j < i; j++) begin
        term = term & p[j];
      end
      c[i] = term;
      for (int j = 0; j < i; j++) begin
        term = g[j];
        for (int m = j + 1; m < i; m++) begin
          term = term & p[m];
        end
        c[i] = c[i] | term;
      end
    end
    return {c[GROUP], c[GROUP-1], p ^ c[GROUP-1:0]};
  endfunction

  // Mask of the operand bits that are still unconsumed after stage k.
  // Bits below the mask boundary have already been summed, so they are not
  // carried forward. After the last stage the mask is all zero.
  function automatic logic [WIDTH-1:0] upper_mask(input int k);
    logic [WIDTH-1:0] m;
    for (int i = 0; i < WIDTH; i++) begin
      m[i] = (i >= (k + 1) * SLICE);
    end
    return m;
  endfunction

  // Handshake and operand conditioning
  logic             stall_s;
  logic             adv_s;
  logic [WIDTH-1:0] b_eff_s;
  logic             cin_eff_s;

  // Per-stage inputs: the port operands for stage 0, otherwise the
  // registers of the previous stage.
  logic [WIDTH-1:0] a_src_s   [STAGES];
  logic [WIDTH-1:0] b_src_s   [STAGES];
  logic [WIDTH-1:0] sum_src_s [STAGES];
  logic             c_src_s   [STAGES];
  logic             v_src_s   [STAGES];

  // Next-state values and pipeline registers
  logic [WIDTH-1:0] a_d   [STAGES];
  logic [WIDTH-1:0] b_d   [STAGES];
  logic [WIDTH-1:0] sum_d [STAGES];
  logic             c_d   [STAGES];
  logic             v_d   [STAGES];
  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] b_q   [STAGES];
  logic [WIDTH-1:0] sum_q [STAGES];
  logic             c_q   [STAGES];
  logic             v_q   [STAGES];
  logic             ovf_d;
  logic             ovf_q;

  // Working values of the carry chain
  logic [GROUP+1:0] grp_s;
  logic             carry_s;
  logic             c_msb_s;

  // Subtraction is a + ~b + ~c_in. The borrow-in is inverted to give the
  // carry-in.
  assign b_eff_s   = b ^ {WIDTH{sub}};
  assign cin_eff_s = c_in ^ sub;

  // The only stall source is a held result at the output. in_ready therefore
  // depends only on the output valid flop and out_ready.
  assign stall_s  = v_q[STAGES-1] & ~out_ready;
  assign adv_s    = ~stall_s;
  assign in_ready = ~stall_s;

  // Stage source selection: stage 0 reads the ports, stage k reads stage k-1.
  always_comb begin
    a_src_s[0]   = a;
    b_src_s[0]   = b_eff_s;
    sum_src_s[0] = '0;
    c_src_s[0]   = cin_eff_s;
    v_src_s[0]   = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      a_src_s[k]   = a_q[k-1];
      b_src_s[k]   = b_q[k-1];
      sum_src_s[k] = sum_q[k-1];
      c_src_s[k]   = c_q[k-1];
      v_src_s[k]   = v_q[k-1];
    end
  end

  // Per-stage arithmetic. Each stage sums its own slice group by group and
  // passes the finished lower slices forward unchanged.
  always_comb begin
    grp_s   = '0;
    carry_s = 1'b0;
    c_msb_s = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      sum_d[k] = sum_src_s[k];
      carry_s  = c_src_s[k];
      for (int j = 0; j < PIPE_GROUPS; j++) begin
        grp_s = cla_group(a_src_s[k][k*SLICE + j*GROUP +: GROUP],
                          b_src_s[k][k*SLICE + j*GROUP +: GROUP],
                          carry_s);
        sum_d[k][k*SLICE + j*GROUP +: GROUP] = grp_s[GROUP-1:0];
        c_msb_s = grp_s[GROUP];
        carry_s = grp_s[GROUP+1];
      end
      c_d[k] = carry_s;
      v_d[k] = v_src_s[k];
      a_d[k] = a_src_s[k] & upper_mask(k);
      b_d[k] = b_src_s[k] & upper_mask(k);
    end
    // After the loop, c_msb_s and carry_s hold the values from the top group
    // of the final stage: the carry into bit WIDTH-1 and the carry out of it.
    ovf_d = c_msb_s ^ carry_s;
  end

  // Pipeline registers: a rigid shift with one global advance enable, cleared
  // asynchronously so that reset drops every in-flight beat at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        sum_q[k] <= '0;
        c_q[k]   <= 1'b0;
        v_q[k]   <= 1'b0;
      end
      ovf_q <= 1'b0;
    end else if (adv_s) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= a_d[k];
        b_q[k]   <= b_d[k];
        sum_q[k] <= sum_d[k];
        c_q[k]   <= c_d[k];
        v_q[k]   <= v_d[k];
      end
      ovf_q <= ovf_d;
    end
  end

  // The last stage is the output register.
  assign sum       = sum_q[STAGES-1];
  assign c_out     = c_q[STAGES-1];
  assign out_valid = v_q[STAGES-1];
  assign ovf       = ovf_q;

endmodule

// File: doc/cla_adder_pipelined.md
# cla_adder_pipelined

Parametrised, pipelined carry-look-ahead adder/subtractor with valid/ready handshakes. Operands are split into GROUP-bit look-ahead groups. Carries ripple between groups, and a register stage sits after every PIPE_GROUPS groups, so throughput is one operation per clock at any width. It is the general-purpose replacement for the fixed-width combinational CLA adders in the arithmetic datapath.

## Interface
- WIDTH, 32: operand width in bits; must be a multiple of GROUP*PIPE_GROUPS.
- GROUP, 4: bits per look-ahead group. Generate/propagate are computed per group; group carry-out is a single look-ahead expression.
- PIPE_GROUPS, 2: groups evaluated per pipeline stage. Number of stages S = WIDTH/(GROUP*PIPE_GROUPS).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- c_in  in  1  carry-in for add; borrow-in for subtract.
- sub  in  1  0 selects add, 1 selects subtract.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts result.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- c_out  out  1  raw carry out of bit WIDTH-1. For subtract, borrow-out = ~c_out.
- ovf  out  1  two's-complement signed overflow.

## Operation
- Effective operands: b_eff = sub ? ~b : b; cin_eff = sub ? ~c_in : c_in.
  - Add computes a + b + c_in.
  - Subtract computes a - b - c_in.
- Per group: g_i = a_i & b_eff_i, p_i = a_i ^ b_eff_i. Internal group carries use full look-ahead: c_{i+1} = g_i | p_i & c_i, expanded. sum_i = p_i ^ c_i.
- Stage k (0..S-1) processes groups k*PIPE_GROUPS to (k+1)*PIPE_GROUPS-1.
- Stage k registers:
  - its sum slice;
  - the carry into stage k+1;
  - the not-yet-consumed upper slices of a and b_eff;
  - the sum slices already finished in earlier stages;
  - a valid bit.
- ovf = carry into bit WIDTH-1 XOR c_out. Both carries are computed in the final stage and registered alongside sum.
- Stall: stall = out_valid & ~out_ready.
  - in_ready = ~stall, a combinational function of the output register and out_ready only.
  - When stalled, every stage holds its contents, including valid bits and data.
  - When not stalled, every stage advances by one. A beat is accepted when in_valid & in_ready.
  - Bubbles are not collapsed; the pipeline is a rigid shift with a global enable.
- No state machine beyond the per-stage valid bits. Behaviour does not depend on the data values.

## Timing
- Latency: S cycles. A beat accepted at edge n appears with out_valid=1 after edge n+S-1, visible in cycle n+S-1.
  - Defaults: S=4, so the result is visible 4 cycles after the accepting edge counted inclusively: accepted at edge 0, out_valid high after edge 3.
- Throughput: 1 beat/cycle when out_ready is held high.
- Output registers are the last stage. sum, c_out, ovf and out_valid are all registered. Only in_ready is combinational.
- Reset (asynchronous, immediate, no clock required):
  - all valid bits = 0;
  - all data registers = 0;
  - sum = 0, c_out = 0, ovf = 0, out_valid = 0;
  - in_ready = 1, since stall is 0.
- Reset asserted mid-operation discards every in-flight beat; no partial result is emitted.
- After reset deasserts, the first edge may accept a beat.
- While out_valid=0, out_ready is ignored and the pipeline always advances.
- While out_valid=1 and out_ready=0, sum, c_out and ovf are held stable.
- Simultaneous output drain and input accept in the same cycle is legal and is the normal streaming case.
- While in_valid=0 and the pipeline is not stalled, a bubble (valid=0) enters stage 0.

## Test plan
- Reset and idle, default parameters: assert rst mid-stream with 3 beats in flight.
  - Required: out_valid=0, sum=0, in_ready=1 immediately.
  - Required: no stale beat emerges after rst is released.
- Add with carry ripple across every group: a=32'hFFFF_FFFF, b=0, c_in=1, sub=0.
  - Required: sum=0, c_out=1, ovf=0, S cycles after accept.
  - Then send a=32'h7FFF_FFFF, b=1, c_in=0. Required: sum=32'h8000_0000, ovf=1, c_out=0.
- Subtract: a=5, b=7, c_in=0, sub=1.
  - Required: sum=32'hFFFF_FFFE, c_out=0 (borrow), ovf=0.
  - Then send a=32'h8000_0000, b=1, c_in=0, sub=1. Required: sum=32'h7FFF_FFFF, ovf=1, c_out=1.
- Streaming: 100 back-to-back random beats with out_ready=1.
  - Required: one result per cycle, in order, each matching a golden model of a ± b ± c_in including c_out and ovf.
- Backpressure: random in_valid and out_ready, with out_ready low for 5 consecutive cycles while the pipeline is full.
  - Required: in_ready=0 throughout that window.
  - Required: outputs held stable, with no beat lost or duplicated.
  - Required: in_ready returns to 1 in the same cycle out_ready rises.
- Parameter sweep with the streaming and backpressure tests repeated:
  - WIDTH=16, GROUP=4, PIPE_GROUPS=4 (S=1, latency 1);
  - WIDTH=64, GROUP=8, PIPE_GROUPS=1 (S=8).
  - Required: latency equals S and all results match the golden model.
